cordic_iter: RTL and testbench

Parametrised iterative CORDIC engine. It is the next generation of the team's fixed 8-bit sine-only unit. Adds configurable width and iteration count, rotation and vectoring modes, valid/ready handshakes, guard bits with output saturation, and reset. It sits between the angle/vector producers and the DSP datapath, and reuses one shift-add stage over ITER cycles.

---
 rtl/cordic_iter.sv | 139 +++++++++++++
 tb/tb_cordic_iter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter.sv
// cordic_iter: iterative CORDIC engine (rotation/vectoring), one shift-add stage reused over ITER cycles
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake; mode, x_in, y_in, z_in sampled on acceptance
//   out_valid/out_ready    result handshake; x_out, y_out, z_out held while out_ready is low
// Data is signed Q2.(WIDTH-2); angles in radians. Results carry the CORDIC gain K (~1.64676).
module cordic_iter #(
  parameter int WIDTH = 16,
  parameter int ITER  = 14,
  parameter int GUARD = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out
);
  localparam int IW = WIDTH + GUARD;
  localparam int CW = $clog2(ITER + 1);
  localparam int SH = 32 - WIDTH;
  localparam logic signed [IW-1:0] MAXV = IW'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [IW-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   mode_q, rdy_q, out_valid_q, d_pos, take;
  logic signed [IW-1:0]   x_q, y_q, z_q, x_d, y_d, z_d, xs, ys;
  logic signed [WIDTH-1:0] x_out_q, y_out_q, z_out_q;
  logic signed [IW-1:0]   atan_t [ITER+1];
  function automatic longint atan_q30(input int i);
    case (i)
      0:  return 843314856;
      1:  return 497837829;
      2:  return 263043836;
      3:  return 133525158;
      4:  return 67021686;
      5:  return 33543515;
      6:  return 16775850;
      7:  return 8388437;
      8:  return 4194282;
      9:  return 2097149;
      10: return 1048575;
      11: return 524287;
      12: return 262143;
      13: return 131071;
      14: return 65535;
      15: return 32767;
      16: return 16383;
      17: return 8191;
      18: return 4095;
      19: return 2047;
      20: return 1023;
      21: return 511;
      22: return 255;
      23: return 127;
      default: return 0;
    endcase
  endfunction
  // (2v + 2^SH) >> (SH+1) rounds to nearest and stays valid when SH is 0
  function automatic logic signed [IW-1:0] atan_r(input int i);
    longint v;
    v = (2 * atan_q30(i) + (longint'(1) <<< SH)) >>> (SH + 1);
    return IW'(v);
  endfunction
  function automatic logic [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    return v > MAXV ? MAXV[WIDTH-1:0] : v < MINV ? MINV[WIDTH-1:0] : v[WIDTH-1:0];
  endfunction
  // extra entry keeps the lookup in range on the final (output) cycle
  for (genvar k = 0; k <= ITER; k++) begin : g_atan
    assign atan_t[k] = atan_r(k);
  end
  // d = +1 when d_pos: rotation steers z to 0, vectoring steers y to 0
  assign d_pos = mode_q ? y_q[IW-1] : ~z_q[IW-1];
  assign xs = x_q >>> cnt_q;
  assign ys = y_q >>> cnt_q;
  assign x_d = d_pos ? x_q - ys : x_q + ys;
  assign y_d = d_pos ? y_q + xs : y_q - xs;
  assign z_d = d_pos ? z_q - atan_t[cnt_q] : z_q + atan_t[cnt_q];
  assign in_ready = rdy_q & (state_q == IDLE | (state_q == DONE & out_ready));
  assign take = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign z_out = z_out_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdy_q <= 1'b0;
      mode_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      out_valid_q <= 1'b0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (take) begin
        state_q <= RUN;
        cnt_q <= '0;
        mode_q <= mode;
        x_q <= IW'(x_in);
        y_q <= IW'(y_in);
        z_q <= IW'(z_in);
        out_valid_q <= 1'b0;
      end else
        case (state_q)
          RUN:
            if (cnt_q == CW'(ITER)) begin
              state_q <= DONE;
              out_valid_q <= 1'b1;
              x_out_q <= sat(x_q);
              y_out_q <= sat(y_q);
              z_out_q <= sat(z_q);
            end else begin
              x_q <= x_d;
              y_q <= y_d;
              z_q <= z_d;
              cnt_q <= cnt_q + CW'(1);
            end
          DONE:
            if (out_ready) begin
              state_q <= IDLE;
              out_valid_q <= 1'b0;
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: directed vectors, handshake corner cases and random operands against a real-arithmetic model
module tb_cordic_iter;
  localparam int W = 16;
  localparam int N = 14;
  typedef struct {
    bit m;
    int x, y, z, ex, ey, ez, tx, ty, tz;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, mode = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic signed [W-1:0] x_in = '0, y_in = '0, z_in = '0, x_out, y_out, z_out;
  int n_chk = 0, n_err = 0;
  real kg;
  vec_t tv [5];
  always #5 clk = ~clk;
  cordic_iter #(.WIDTH(W), .ITER(N), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );
  task automatic chk(input string nm, input int act, input int exp, input int tol);
    n_chk++;
    if (act > exp + tol || act < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", nm, act, exp, tol);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int satr(input real v);
    real r;
    r = v >= 0.0 ? v + 0.5 : v - 0.5;
    if (r > 32767.0) return 32767;
    if (r < -32768.0) return -32768;
    return $rtoi(r);
  endfunction
  // ideal CORDIC result: exact rotation / polar conversion scaled by the finite-iteration gain
  task automatic model(input bit m, input int x, input int y, input int z, output int ex, output int ey, output int ez);
    real a;
    a = z / 16384.0;
    if (!m) begin
      ex = satr(kg * (x * $cos(a) - y * $sin(a)));
      ey = satr(kg * (x * $sin(a) + y * $cos(a)));
      ez = 0;
    end else begin
      ex = satr(kg * $sqrt(real'(x) * x + real'(y) * y));
      ey = 0;
      ez = satr(z + $atan2(real'(y), real'(x)) * 16384.0);
    end
  endtask
  task automatic send(input bit m, input int x, input int y, input int z);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      tick;
      g++;
    end
    chk("in_ready_wait", int'(in_ready), 1, 0);
    in_valid = 1'b1;
    mode = m;
    x_in = W'(x);
    y_in = W'(y);
    z_in = W'(z);
    tick;
    in_valid = 1'b0;
    mode = 1'($urandom);
    x_in = W'($urandom);
    y_in = W'($urandom);
    z_in = W'($urandom);
  endtask
  task automatic wait_out(input string nm, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick;
      lat++;
    end
    chk(nm, lat, N + 1, 0);
  endtask
  task automatic op(input string nm, input bit m, input int x, input int y, input int z,
                    input int ex, input int ey, input int ez, input int tx, input int ty, input int tz);
    int lat;
    out_ready = 1'b1;
    send(m, x, y, z);
    wait_out({nm, "_lat"}, lat);
    chk({nm, "_x"}, x_out, ex, tx);
    chk({nm, "_y"}, y_out, ey, ty);
    chk({nm, "_z"}, z_out, ez, tz);
    tick;
  endtask
  initial begin
    int ex, ey, ez, lat, hx, hy, hz;
    bit m;
    int x, y, z;
    real p;
    tv[0] = '{0, 9949, 0, 8579, 14189, 8192, 0, 8, 8, 8};
    tv[1] = '{0, 9949, 0, -12868, 11585, -11585, 0, 8, 8, 8};
    tv[2] = '{0, 9949, 0, 0, 16384, 0, 0, 8, 8, 8};
    tv[3] = '{1, 8192, 8192, 0, 19079, 0, 12868, 8, 8, 8};
    tv[4] = '{1, 32767, 32767, 0, 32767, 0, 12868, 0, 32, 8};
    kg = 1.0;
    p = 1.0;
    for (int i = 0; i < N; i++) begin
      kg = kg * $sqrt(1.0 + p);
      p = p * 0.25;
    end
    #12;
    chk("rst_in_ready", int'(in_ready), 0, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_x", x_out, 0, 0);
    chk("rst_z", z_out, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", int'(in_ready), 0, 0);
    tick;
    chk("rel_in_ready", int'(in_ready), 1, 0);
    for (int i = 0; i < 5; i++)
      op($sformatf("vec%0d", i), tv[i].m, tv[i].x, tv[i].y, tv[i].z,
         tv[i].ex, tv[i].ey, tv[i].ez, tv[i].tx, tv[i].ty, tv[i].tz);
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom_range(0, 1));
      if (!m) begin
        x = int'($urandom_range(0, 16384)) - 8192;
        y = int'($urandom_range(0, 16384)) - 8192;
        z = int'($urandom_range(0, 50000)) - 25000;
      end else begin
        x = int'($urandom_range(6000, 8192));
        y = int'($urandom_range(0, 16384)) - 8192;
        z = int'($urandom_range(0, 8192)) - 4096;
      end
      model(m, x, y, z, ex, ey, ez);
      op($sformatf("rnd%0d", i), m, x, y, z, ex, ey, ez, 24, 24, 24);
    end
    out_ready = 1'b0;
    send(1'b1, 8192, 8192, 0);
    wait_out("bp_lat", lat);
    hx = x_out;
    hy = y_out;
    hz = z_out;
    chk("bp_x", hx, 19079, 8);
    chk("bp_z", hz, 12868, 8);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("bp_valid", int'(out_valid), 1, 0);
      chk("bp_in_ready", int'(in_ready), 0, 0);
      chk("bp_hold_x", x_out, hx, 0);
      chk("bp_hold_y", y_out, hy, 0);
      chk("bp_hold_z", z_out, hz, 0);
      x_in = W'($urandom);
    end
    mode = 1'b0;
    x_in = 16'sd9949;
    y_in = '0;
    z_in = 16'sd8579;
    out_ready = 1'b1;
    #1;
    chk("handoff_ready", int'(in_ready), 1, 0);
    tick;
    in_valid = 1'b0;
    chk("handoff_valid_drop", int'(out_valid), 0, 0);
    wait_out("handoff_lat", lat);
    chk("handoff_x", x_out, 14189, 8);
    chk("handoff_y", y_out, 8192, 8);
    chk("handoff_z", z_out, 0, 8);
    tick;
    send(1'b0, 9949, 0, -12868);
    repeat (6) tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0, 0);
    chk("mid_rst_ready", int'(in_ready), 0, 0);
    chk("mid_rst_x", x_out, 0, 0);
    chk("mid_rst_y", y_out, 0, 0);
    chk("mid_rst_z", z_out, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready_pre", int'(in_ready), 0, 0);
    tick;
    chk("post_rst_ready", int'(in_ready), 1, 0);
    chk("post_rst_valid", int'(out_valid), 0, 0);
    model(1'b0, 9949, 0, -12868, ex, ey, ez);
    op("post_rst", 1'b0, 9949, 0, -12868, ex, ey, ez, 8, 8, 8);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1);
  end
endmodule
